// File: rtl/mem_stage.sv
// Memory-access stage: resolves branches, performs word loads/stores against a
// local data memory with configurable latency, and drives the MEM/WB register.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_branch_pc,
    input  logic [31:0] i_alu_result,
    input  logic        i_zero,
    input  logic [31:0] i_read_data2,
    input  logic [4:0]  i_write_reg,
    input  logic [1:0]  i_WB_control,
    input  logic [2:0]  i_MEM_control,
    output logic        o_pc_src,
    output logic [31:0] o_branch_pc,
    output logic        o_stall,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_result,
    output logic [4:0]  o_write_reg,
    output logic [1:0]  o_WB_control
);
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       read_data_q, read_data_d;
    logic [31:0]       alu_result_q, alu_result_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [1:0]        wb_control_q, wb_control_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              mem_read, mem_write, req;
    logic              stall, complete, bubble, mem_we;
    logic              unused_addr_bits;

    // Word addressing: byte offset and bits above the array size are dropped.
    assign idx              = i_alu_result[ADDR_W+1:2];
    assign unused_addr_bits = ^{i_alu_result[31:ADDR_W+2], i_alu_result[1:0]};

    assign mem_read  = i_MEM_control[1];
    assign mem_write = i_MEM_control[0];
    assign req       = mem_read | mem_write;

    assign o_pc_src    = i_MEM_control[2] & i_zero;
    assign o_branch_pc = i_branch_pc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        bubble   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (MEM_LATENCY == 1) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must both drop the stall and suppress any store still pending.
    assign o_stall = stall & ~i_rst;
    assign mem_we  = complete & mem_write & ~i_rst;

    always_comb begin
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        wb_control_d = wb_control_q;
        if (bubble) begin
            wb_control_d = 2'b00;
        end else begin
            alu_result_d = i_alu_result;
            write_reg_d  = i_write_reg;
            wb_control_d = i_WB_control;
            if (complete && mem_read) read_data_d = mem[idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            wb_control_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            wb_control_q <= wb_control_d;
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[idx] <= i_read_data2;
    end

    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_write_reg  = write_reg_q;
    assign o_WB_control = wb_control_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance at latency 1, one at latency 3.
module tb_mem_stage;
    typedef struct packed {
        logic [31:0] bpc;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic [2:0]  mc;
    } op_t;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    op_t         in_s   [2];
    logic        stall  [2];
    logic        pcs    [2];
    logic [31:0] bpo    [2];
    logic [31:0] rd_o   [2];
    logic [31:0] alu_o  [2];
    logic [4:0]  wr_o   [2];
    logic [1:0]  wb_o   [2];

    logic [31:0] model   [2][256];
    logic [31:0] last_rd [2];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst),
        .i_branch_pc(in_s[0].bpc), .i_alu_result(in_s[0].alu), .i_zero(in_s[0].zero),
        .i_read_data2(in_s[0].wd), .i_write_reg(in_s[0].wr),
        .i_WB_control(in_s[0].wb), .i_MEM_control(in_s[0].mc),
        .o_pc_src(pcs[0]), .o_branch_pc(bpo[0]), .o_stall(stall[0]),
        .o_read_data(rd_o[0]), .o_alu_result(alu_o[0]),
        .o_write_reg(wr_o[0]), .o_WB_control(wb_o[0])
    );

    mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(3)) u_l3 (
        .i_clk(clk), .i_rst(rst),
        .i_branch_pc(in_s[1].bpc), .i_alu_result(in_s[1].alu), .i_zero(in_s[1].zero),
        .i_read_data2(in_s[1].wd), .i_write_reg(in_s[1].wr),
        .i_WB_control(in_s[1].wb), .i_MEM_control(in_s[1].mc),
        .o_pc_src(pcs[1]), .o_branch_pc(bpo[1]), .o_stall(stall[1]),
        .o_read_data(rd_o[1]), .o_alu_result(alu_o[1]),
        .o_write_reg(wr_o[1]), .o_WB_control(wb_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [2:0] mc, input logic [1:0] wb,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
        op_t o;
        o.bpc = 32'h0; o.zero = 1'b0;
        o.mc = mc; o.wb = wb; o.alu = alu; o.wd = wd; o.wr = wr;
        return o;
    endfunction

    // Called on a negedge; returns on the negedge after the completion edge.
    task automatic run_op(input int u, input op_t op);
        exp_t e;
        int   idx;
        int   stalls;
        int   exp_stalls;
        idx = int'(op.alu[9:2]);
        in_s[u] = op;
        e.alu = op.alu; e.wr = op.wr; e.wb = op.wb; e.rd = last_rd[u];
        if (op.mc[1]) e.rd = model[u][idx];
        if (op.mc[0]) model[u][idx] = op.wd;
        last_rd[u] = e.rd;
        sb.push_back(e);
        exp_stalls = (u == 1 && (op.mc[1] || op.mc[0])) ? 2 : 0;
        stalls = 0;
        #1;
        while (stall[u] === 1'b1 && stalls <= 20) begin
            stalls++;
            @(posedge clk);
            @(negedge clk);
            chk("bubble_wb", 32'(wb_o[u]), 32'h0);
        end
        if (stalls > 20) chk("stall_bound", stalls, 20);
        chk("stall_cycles", stalls, exp_stalls);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("read_data", rd_o[u], e.rd);
        chk("alu_result", alu_o[u], e.alu);
        chk("write_reg", 32'(wr_o[u]), 32'(e.wr));
        chk("wb_control", 32'(wb_o[u]), 32'(e.wb));
    endtask

    initial begin
        rst = 1'b1;
        in_s[0] = mk(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
        in_s[1] = in_s[0];
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        chk("rst_alu", alu_o[0], 32'h0);
        chk("rst_wb", 32'(wb_o[1]), 32'h0);
        chk("rst_stall", 32'(stall[1]), 32'h0);
        rst = 1'b0;

        // Plain ALU ops pass through in one edge, including at latency 3.
        run_op(0, mk(3'b000, 2'b10, 32'h0000_0055, 32'h0, 5'd3));
        run_op(1, mk(3'b000, 2'b10, 32'h0000_0077, 32'h0, 5'd9));

        // Asynchronous reset mid-cycle with a request pending on the L=3 unit.
        in_s[1] = mk(3'b010, 2'b11, 32'h10, 32'h0, 5'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_alu", alu_o[0], 32'h0);
        chk("arst_wr", 32'(wr_o[0]), 32'h0);
        chk("arst_wb", 32'(wb_o[0]), 32'h0);
        chk("arst_alu3", alu_o[1], 32'h0);
        chk("arst_stall", 32'(stall[1]), 32'h0);
        in_s[1] = mk(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // L=1: store, load, read-modify-write, reload.
        run_op(0, mk(3'b001, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0));
        run_op(0, mk(3'b010, 2'b11, 32'h10, 32'h0, 5'd5));
        run_op(0, mk(3'b011, 2'b11, 32'h10, 32'hCAFEF00D, 5'd6));
        run_op(0, mk(3'b010, 2'b11, 32'h13, 32'h0, 5'd7));

        // Branch resolution is combinational.
        in_s[0] = mk(3'b100, 2'b00, 32'h0, 32'h0, 5'd0);
        in_s[0].zero = 1'b1;
        in_s[0].bpc  = 32'h40;
        #1;
        chk("pc_src_taken", 32'(pcs[0]), 32'h1);
        chk("branch_pc", bpo[0], 32'h40);
        in_s[0].zero = 1'b0;
        #1;
        chk("pc_src_not_taken", 32'(pcs[0]), 32'h0);
        chk("branch_stall", 32'(stall[0]), 32'h0);
        run_op(0, in_s[0]);

        // L=3 accesses, back to back.
        run_op(1, mk(3'b001, 2'b00, 32'h20, 32'h0, 5'd0));
        run_op(1, mk(3'b001, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0));
        run_op(1, mk(3'b010, 2'b11, 32'h10, 32'h0, 5'd8));
        run_op(1, mk(3'b001, 2'b00, 32'h3FC + 32'h400, 32'h12345678, 5'd0));
        run_op(1, mk(3'b010, 2'b11, 32'h3FC, 32'h0, 5'd12));
        run_op(1, mk(3'b000, 2'b10, 32'h0000_1234, 32'h0, 5'd2));

        // Reset on the second stall cycle of a store: the store must not land.
        in_s[1] = mk(3'b001, 2'b00, 32'h20, 32'hAAAAAAAA, 5'd0);
        @(posedge clk);
        @(negedge clk);
        chk("pre_abort_stall", 32'(stall[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_stall", 32'(stall[1]), 32'h0);
        in_s[1] = mk(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        run_op(1, mk(3'b010, 2'b11, 32'h20, 32'h0, 5'd4));
        run_op(1, mk(3'b010, 2'b01, 32'h10, 32'h0, 5'd31));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipelined CPU. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs. It resolves the branch decision, performs word loads and stores against an internal data memory with a configurable access latency, and drives the MEM/WB pipeline register that feeds write-back. While a multi-cycle access is in flight it raises a stall and inserts bubbles into write-back.

## Interface
- DEPTH, 256: data memory size in 32-bit words (power of two).
- ADDR_W, 8: log2(DEPTH).
- MEM_LATENCY, 1: cycles per load/store (≥1); 1 = single-cycle, no stall.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_branch_pc  in  32  branch target from EX/MEM.
- i_alu_result  in  32  ALU result; the data address for loads and stores.
- i_zero  in  1  ALU zero flag.
- i_read_data2  in  32  store data.
- i_write_reg  in  5  destination register number.
- i_WB_control  in  2  [1]=RegWrite, [0]=MemtoReg.
- i_MEM_control  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- o_pc_src  out  1  branch taken = Branch & i_zero; combinational.
- o_branch_pc  out  32  i_branch_pc passthrough; combinational.
- o_stall  out  1  hold upstream stages and PC; combinational.
- o_read_data  out  32  MEM/WB: loaded word.
- o_alu_result  out  32  MEM/WB: ALU result.
- o_write_reg  out  5  MEM/WB: destination register.
- o_WB_control  out  2  MEM/WB: write-back controls.

## Operation
- Word index = i_alu_result[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Memory array is not cleared by reset. Contents are undefined until written.
- A memory request (req) is MemRead | MemWrite.
- FSM states are IDLE and WAIT, plus a down-counter cnt of width ≥ log2(MEM_LATENCY).
- IDLE, no req: no access. The MEM/WB register captures the current inputs.
- IDLE, req, MEM_LATENCY=1: the access completes at this edge and the state stays IDLE.
- IDLE, req, MEM_LATENCY>1: o_stall=1. At the edge, go to WAIT with cnt=MEM_LATENCY-2, and load a bubble into MEM/WB.
- WAIT, cnt≠0: o_stall=1. At the edge, cnt decrements and another bubble is loaded.
- WAIT, cnt=0: o_stall=0. The access completes at this edge and the state returns to IDLE.
- Completion of a store: mem[index] ← i_read_data2, written exactly once per request.
- Completion of a load: o_read_data ← mem[index], using the pre-edge contents.
- Completion of any access: o_alu_result, o_write_reg and o_WB_control capture the inputs.
- Bubble: o_WB_control ← 2'b00. The other MEM/WB outputs are don't-care but must hold their previous values.
- Upstream must hold all inputs stable while o_stall=1. Inputs are sampled only at the completion edge.
- MemRead and MemWrite both set: the word is written, and o_read_data captures the old word.
- Non-memory instructions (ALU, branch) never stall.
- o_pc_src is independent of the FSM.
- Back-to-back requests: a new request presented in the cycle after completion starts a fresh access from IDLE. There are no idle gaps beyond the latency.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, and o_read_data, o_alu_result, o_write_reg, o_WB_control all = 0. The memory array is unchanged.
- During reset, o_stall=0. o_pc_src and o_branch_pc follow their inputs combinationally.
- Reset asserted mid-access: the FSM aborts to IDLE immediately, the pending store is not performed, and no load data is delivered.
- Latency: the MEM/WB outputs are valid 1 edge after the inputs, for non-memory instructions and when MEM_LATENCY=1.
- Memory instructions with MEM_LATENCY=L: the request occupies the stage for L cycles, o_stall is high for the first L-1 of them, and the MEM/WB outputs are valid after the L-th edge.
- o_stall depends only on the current state, cnt and req. It has no combinational path from i_alu_result or the data inputs.

## Test plan
- Reset: assert i_rst mid-cycle. All MEM/WB outputs go to 0 immediately, with no clock edge needed; o_stall=0.
- L=1, store then load:
  - Store: MEM_CONTROL=001, addr=0x10, data=0xDEADBEEF.
  - Next cycle load: MEM_CONTROL=010, WB=11, addr=0x10, write_reg=5.
  - Required: after the following edge, o_read_data=0xDEADBEEF, o_write_reg=5, o_WB_control=11, and o_stall never asserts.
- Branch: MEM_CONTROL=100, i_zero=1, i_branch_pc=0x40. Required: o_pc_src=1 and o_branch_pc=0x40 in the same cycle. With i_zero=0, o_pc_src=0.
- L=3, load from 0x10 (holding 0xDEADBEEF):
  - o_stall=1 for 2 cycles, then 0.
  - o_WB_control=00 after edges 1 and 2.
  - After edge 3, o_read_data=0xDEADBEEF and o_WB_control=11.
- L=3, store 0x12345678 to address 0x3FC+0x400 (wraps to index 255): a later load from 0x3FC returns 0x12345678.
- L=3, reset on the 2nd stall cycle of a store of 0xAAAAAAAA to 0x20 (previously 0x0): after release, a load from 0x20 returns 0x0, and the FSM is IDLE with o_stall=0.
